// File: rtl/vga_timing_pkg.sv
// 640x480@60 Hz raster constants shared by the sync generator and its neighbours.
package vga_timing_pkg;
  localparam int COORD_W  = 10;
  localparam int H_VIS    = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_VIS    = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;   // 800
  localparam int V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;   // 525
  localparam int HS_START = H_VIS + H_FP;                   // 656
  localparam int HS_END   = HS_START + H_SYNC - 1;          // 751
  localparam int VS_START = V_VIS + V_FP;                   // 490
  localparam int VS_END   = VS_START + V_SYNC - 1;          // 491
endpackage

// File: rtl/pixel_tick_div.sv
// Free-running mod-TICK_DIV divider producing a registered one-clock pixel tick.
module pixel_tick_div #(
  parameter int TICK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  output logic p_tick,
  output logic tick_next
);
  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  // tick_next flags the cycle whose edge will raise p_tick
  assign tick_next = (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt    <= '0;
      p_tick <= 1'b0;
    end else begin
      p_tick <= tick_next;
      cnt    <= tick_next ? '0 : cnt + CW'(1);
    end
  end
endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel tick, coordinates, syncs and visible-area flag.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int TICK_DIV = 4,
  parameter int H_VIS    = vga_timing_pkg::H_VIS,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_VIS    = vga_timing_pkg::V_VIS,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  output logic               p_tick,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               line_end,
  output logic               frame_end
);
  localparam logic [COORD_W-1:0] H_MAX = COORD_W'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [COORD_W-1:0] V_MAX = COORD_W'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [COORD_W-1:0] H_VC  = COORD_W'(H_VIS);
  localparam logic [COORD_W-1:0] V_VC  = COORD_W'(V_VIS);
  localparam logic [COORD_W-1:0] HS_S  = COORD_W'(H_VIS + H_FP);
  localparam logic [COORD_W-1:0] HS_E  = COORD_W'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_S  = COORD_W'(V_VIS + V_FP);
  localparam logic [COORD_W-1:0] VS_E  = COORD_W'(V_VIS + V_FP + V_SYNC - 1);

  logic               tick_next;
  logic [COORD_W-1:0] x_nxt, y_nxt;

  pixel_tick_div #(.TICK_DIV(TICK_DIV)) u_div (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .p_tick    (p_tick),
    .tick_next (tick_next)
  );

  always_comb begin
    x_nxt = pix_x;
    y_nxt = pix_y;
    if (p_tick) begin
      x_nxt = (pix_x == H_MAX) ? '0 : pix_x + COORD_W'(1);
      if (pix_x == H_MAX)
        y_nxt = (pix_y == V_MAX) ? '0 : pix_y + COORD_W'(1);
    end
  end

  // Decodes load from next-state coordinates so they never skew against pix_x/pix_y.
  // They first load on the edge that raises the first tick, keeping video_on low
  // during the idle stretch right after reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pix_x    <= '0;
      pix_y    <= '0;
      hsync    <= 1'b1;
      vsync    <= 1'b1;
      video_on <= 1'b0;
    end else begin
      pix_x <= x_nxt;
      pix_y <= y_nxt;
      if (p_tick || tick_next) begin
        hsync    <= !((x_nxt >= HS_S) && (x_nxt <= HS_E));
        vsync    <= !((y_nxt >= VS_S) && (y_nxt <= VS_E));
        video_on <= (x_nxt < H_VC) && (y_nxt < V_VC);
      end
    end
  end

  assign line_end  = p_tick && (pix_x == H_MAX);
  assign frame_end = line_end && (pix_y == V_MAX);
endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench: default-timing instance for tick/line checks, shrunken instance for frame checks.
module tb_vga_sync_gen;
  typedef struct packed {
    logic       tick;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       von;
    logic       le;
    logic       fe;
  } exp_t;

  localparam int B_TD = 3, B_HV = 10, B_HFP = 2, B_HS = 3, B_HBP = 2;
  localparam int B_VV = 6, B_VFP = 2, B_VS = 2, B_VBP = 3;
  localparam int B_HT = B_HV + B_HFP + B_HS + B_HBP;
  localparam int B_VT = B_VV + B_VFP + B_VS + B_VBP;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0, rst_b = 1'b0;
  logic a_tick, a_hs, a_vs, a_von, a_le, a_fe;
  logic b_tick, b_hs, b_vs, b_von, b_le, b_fe;
  logic [9:0] a_x, a_y, b_x, b_y;
  exp_t obs_a, obs_b, e;
  int checks = 0, failures = 0;
  int c_a = 0, c_b = 0;

  vga_sync_gen dut_a (
    .clk_i(clk), .rst_n_i(rst_a), .p_tick(a_tick), .pix_x(a_x), .pix_y(a_y),
    .hsync(a_hs), .vsync(a_vs), .video_on(a_von), .line_end(a_le), .frame_end(a_fe));

  vga_sync_gen #(
    .TICK_DIV(B_TD), .H_VIS(B_HV), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
    .V_VIS(B_VV), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP)
  ) dut_b (
    .clk_i(clk), .rst_n_i(rst_b), .p_tick(b_tick), .pix_x(b_x), .pix_y(b_y),
    .hsync(b_hs), .vsync(b_vs), .video_on(b_von), .line_end(b_le), .frame_end(b_fe));

  assign obs_a = {a_tick, a_x, a_y, a_hs, a_vs, a_von, a_le, a_fe};
  assign obs_b = {b_tick, b_x, b_y, b_hs, b_vs, b_von, b_le, b_fe};

  // clocks elapsed since reset release
  always @(posedge clk) c_a <= rst_a ? c_a + 1 : 0;
  always @(posedge clk) c_b <= rst_b ? c_b + 1 : 0;

  // Expected outputs c clocks after release: ticks every td clocks, each tick
  // advances a raster position k that maps onto (x, y) by division.
  function automatic exp_t model(int c, int td, int hv, int hfp, int hs, int hbp,
                                 int vv, int vfp, int vs, int vbp);
    exp_t r;
    int ht, vt, k, x, y;
    ht = hv + hfp + hs + hbp;
    vt = vv + vfp + vs + vbp;
    k  = (c < 1) ? 0 : (c - 1) / td;
    x  = k % ht;
    y  = (k / ht) % vt;
    r.tick = (c >= td) && (c % td == 0);
    r.x    = 10'(x);
    r.y    = 10'(y);
    r.hs   = !(x >= hv + hfp && x < hv + hfp + hs);
    r.vs   = !(y >= vv + vfp && y < vv + vfp + vs);
    r.von  = (c >= td) && x < hv && y < vv;
    r.le   = r.tick && x == ht - 1;
    r.fe   = r.le && y == vt - 1;
    return r;
  endfunction

  function automatic exp_t model_a(int c);
    return model(c, 4, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction

  function automatic exp_t model_b(int c);
    return model(c, B_TD, B_HV, B_HFP, B_HS, B_HBP, B_VV, B_VFP, B_VS, B_VBP);
  endfunction

  task automatic test_reset;
    int first = -1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (obs_a !== model_a(0)) begin
        failures++;
        $display("FAIL reset_hold got=%h exp=%h", obs_a, model_a(0));
      end
    end
    rst_a = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      e = model_a(c_a);
      checks++;
      if (obs_a !== e) begin
        failures++;
        $display("FAIL first_tick_seq c=%0d got=%h exp=%h", c_a, obs_a, e);
      end
      if (a_tick && first < 0) first = i;
    end
    checks++;
    if (first !== 4) begin
      failures++;
      $display("FAIL first_tick_clock got=%0d exp=4", first);
    end
  endtask

  task automatic test_tick_cadence;
    int n = 0, last = -1, bad_gap = 0, bad_w = 0;
    logic prev = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      e = model_a(c_a);
      checks++;
      if (obs_a !== e) begin
        failures++;
        $display("FAIL cadence c=%0d got=%h exp=%h", c_a, obs_a, e);
      end
      if (a_tick) begin
        n++;
        if (prev) bad_w++;
        if (last >= 0 && i - last != 4) bad_gap++;
        last = i;
      end
      prev = a_tick;
    end
    checks++;
    if (n !== 100 || bad_gap !== 0 || bad_w !== 0) begin
      failures++;
      $display("FAIL tick_count got=%0d gaps=%0d wide=%0d exp=100/0/0", n, bad_gap, bad_w);
    end
  endtask

  task automatic test_horizontal;
    int hs_lo = 0, vis = 0, le_n = 0, extra;
    extra = $urandom_range(0, 3);
    for (int i = 0; i < extra; i++) @(negedge clk);
    // 3200 consecutive clocks span exactly 800 ticks, one full line period
    for (int i = 0; i < 3200; i++) begin
      @(negedge clk);
      e = model_a(c_a);
      checks++;
      if (obs_a !== e) begin
        failures++;
        $display("FAIL horiz c=%0d got=%h exp=%h", c_a, obs_a, e);
      end
      if (a_tick) begin
        if (!a_hs) hs_lo++;
        if (a_von) vis++;
        if (a_le) le_n++;
      end
    end
    checks++;
    if (hs_lo !== 96 || vis !== 640 || le_n !== 1) begin
      failures++;
      $display("FAIL line_counts hs=%0d vis=%0d le=%0d exp=96/640/1", hs_lo, vis, le_n);
    end
  endtask

  task automatic test_frame;
    int vs_lo = 0, fe_n = 0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    rst_b = 1'b1;
    for (int i = 0; i < B_TD * B_HT * B_VT + B_TD; i++) begin
      @(negedge clk);
      e = model_b(c_b);
      checks++;
      if (obs_b !== e) begin
        failures++;
        $display("FAIL frame c=%0d got=%h exp=%h", c_b, obs_b, e);
      end
      if (b_tick && !b_vs) vs_lo++;
      if (b_fe) fe_n++;
    end
    checks++;
    if (vs_lo !== B_VS * B_HT || fe_n !== 1 || b_x !== 10'd0 || b_y !== 10'd0) begin
      failures++;
      $display("FAIL frame_counts vs=%0d fe=%0d x=%0d y=%0d exp=%0d/1/0/0",
               vs_lo, fe_n, b_x, b_y, B_VS * B_HT);
    end
  endtask

  task automatic test_bounds;
    int mx = 0, my = 0, vis = 0, fe_n = 0;
    for (int i = 0; i < 3 * B_TD * B_HT * B_VT; i++) begin
      @(negedge clk);
      e = model_b(c_b);
      checks++;
      if (obs_b !== e) begin
        failures++;
        $display("FAIL bounds c=%0d got=%h exp=%h", c_b, obs_b, e);
      end
      if (int'(b_x) > mx) mx = int'(b_x);
      if (int'(b_y) > my) my = int'(b_y);
      if (b_tick && b_von) vis++;
      if (b_fe) fe_n++;
    end
    checks++;
    if (mx !== B_HT - 1 || my !== B_VT - 1 || vis !== 3 * B_HV * B_VV || fe_n !== 3) begin
      failures++;
      $display("FAIL bound_counts mx=%0d my=%0d vis=%0d fe=%0d exp=%0d/%0d/%0d/3",
               mx, my, vis, fe_n, B_HT - 1, B_VT - 1, 3 * B_HV * B_VV);
    end
  endtask

  task automatic test_mid_reset;
    int budget = 0, hold;
    exp_t z;
    // default instance: stop at pix_x=300
    while (a_x != 10'd300 && budget < 4000) begin
      @(negedge clk);
      budget++;
    end
    checks++;
    if (a_x !== 10'd300) begin
      failures++;
      $display("FAIL reach_x300 got=%0d exp=300", a_x);
    end
    // shrunken instance: random point in the frame
    for (int i = 0; i < int'($urandom_range(20, 600)); i++) @(negedge clk);
    #2;
    rst_a = 1'b0;
    rst_b = 1'b0;
    #1;
    z = model_a(0);
    checks++;
    if (obs_a !== z) begin
      failures++;
      $display("FAIL async_reset_a got=%h exp=%h", obs_a, z);
    end
    z = model_b(0);
    checks++;
    if (obs_b !== z) begin
      failures++;
      $display("FAIL async_reset_b got=%h exp=%h", obs_b, z);
    end
    hold = $urandom_range(1, 4);
    for (int i = 0; i < hold; i++) @(negedge clk);
    rst_a = 1'b1;
    rst_b = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      e = model_a(c_a);
      checks++;
      if (obs_a !== e) begin
        failures++;
        $display("FAIL restart_a c=%0d got=%h exp=%h", c_a, obs_a, e);
      end
      e = model_b(c_b);
      checks++;
      if (obs_b !== e) begin
        failures++;
        $display("FAIL restart_b c=%0d got=%h exp=%h", c_b, obs_b, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_tick_cadence();
    test_horizontal();
    test_frame();
    test_bounds();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
